// File: rtl/serial_comparator_pkg.sv
// Shared types and defaults for the MSB-first serial magnitude comparator.
package serial_comparator_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    EQ,
    LT,
    GT
  } decision_t;

endpackage

// File: rtl/serial_comparator_bit_counter.sv
// Counts accepted bit pairs of one operand; saturates at WIDTH-1 so it never wraps.
module bit_counter
  import serial_comparator_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [CNT_W-1:0] count_q, count_d;

  assign terminal = (count_q == CNT_W'(WIDTH - 1));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !terminal) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/serial_comparator.sv
// Unsigned serial comparator: operands arrive MSB-first one bit pair per valid cycle;
// the first differing pair decides the result, reported with a one-cycle done pulse.
module serial_comparator
  import serial_comparator_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bit_valid,
  input  logic a_bit,
  input  logic b_bit,
  output logic busy,
  output logic done,
  output logic lesser,
  output logic greater,
  output logic equal
);

  state_t    state_q, state_d;
  decision_t decision_q, decision_d;
  logic      lesser_q, lesser_d;
  logic      greater_q, greater_d;
  logic      equal_q, equal_d;
  logic      cnt_clear;
  logic      cnt_enable;
  logic      cnt_last;

  bit_counter #(
    .WIDTH(WIDTH)
  ) u_bit_counter (
    .clk     (clk),
    .rst     (rst),
    .clear   (cnt_clear),
    .enable  (cnt_enable),
    .terminal(cnt_last)
  );

  assign busy    = (state_q == COMPARE);
  assign done    = (state_q == DONE);
  assign lesser  = lesser_q;
  assign greater = greater_q;
  assign equal   = equal_q;

  always_comb begin
    state_d    = state_q;
    decision_d = decision_q;
    lesser_d   = lesser_q;
    greater_d  = greater_q;
    equal_d    = equal_q;
    cnt_clear  = 1'b0;
    cnt_enable = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = COMPARE;
          decision_d = EQ;
          lesser_d   = 1'b0;
          greater_d  = 1'b0;
          equal_d    = 1'b0;
          cnt_clear  = 1'b1;
        end
      end

      COMPARE: begin
        if (bit_valid) begin
          cnt_enable = 1'b1;
          if (decision_q == EQ) begin
            if (a_bit && !b_bit) begin
              decision_d = GT;
            end else if (!a_bit && b_bit) begin
              decision_d = LT;
            end
          end
          // Flags load from the updated decision so a deciding LSB is not lost.
          if (cnt_last) begin
            state_d   = DONE;
            lesser_d  = (decision_d == LT);
            greater_d = (decision_d == GT);
            equal_d   = (decision_d == EQ);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      decision_q <= EQ;
      lesser_q   <= 1'b0;
      greater_q  <= 1'b0;
      equal_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      decision_q <= decision_d;
      lesser_q   <= lesser_d;
      greater_q  <= greater_d;
      equal_q    <= equal_d;
    end
  end

endmodule

// File: doc/serial_comparator.md
SERIAL_COMPARATOR -- requirements
Module: serial_comparator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand length in bits (legal range 2..32).
REQ-002 The block SHALL have input clk, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have input rst, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have input start, 1 bit: begin a new comparison.
REQ-005 The block SHALL have input bit_valid, 1 bit: a_bit/b_bit carry one operand bit pair this cycle.
REQ-006 The block SHALL have inputs a_bit and b_bit, 1 bit each: current bits of operands a and b, sent MSB-first, unsigned.
REQ-007 The block SHALL have output busy, 1 bit: a comparison is in progress.
REQ-008 The block SHALL have output done, 1 bit: one-cycle pulse marking a completed result.
REQ-009 The block SHALL have outputs lesser, greater and equal, 1 bit each: the result flags for a<b, a>b and a==b.

Function
REQ-010 The block SHALL have states IDLE, COMPARE and DONE.
REQ-011 IDLE->COMPARE on start; the same edge SHALL clear the bit count to 0, clear all result flags to 0 and set the internal decision to EQ.
REQ-012 In IDLE, bit_valid SHALL be ignored, including when it is asserted in the same cycle as start.
REQ-013 In COMPARE, each cycle with bit_valid=1 SHALL accept one bit pair and increment the count; cycles with bit_valid=0 SHALL leave all state unchanged.
REQ-014 While the decision is EQ, an accepted pair with a_bit=1, b_bit=0 SHALL set decision GT, and a_bit=0, b_bit=1 SHALL set decision LT.
REQ-015 Once the decision is GT or LT it SHALL stay frozen for the rest of the operand; later bits are still counted.
REQ-016 When the pair accepted has count==WIDTH-1, the next state SHALL be DONE.
REQ-017 In DONE, done SHALL be 1 for exactly that one cycle, and the state SHALL then go to IDLE unconditionally.
REQ-018 At the entry to DONE, the flags SHALL be loaded from the decision, exactly one-hot: GT->greater, LT->lesser, EQ->equal.
REQ-019 The flags SHALL hold their value until the next start or rst.
REQ-020 Latency: done and valid flags SHALL appear on the cycle immediately after the WIDTH-th accepted bit.
REQ-021 busy SHALL be 1 exactly while in COMPARE.
REQ-022 start SHALL be ignored in COMPARE and in DONE; start in the cycle after DONE, i.e. in IDLE, SHALL be accepted.
REQ-023 The counter SHALL be $clog2(WIDTH) bits wide, SHALL not wrap within an operand, and SHALL be reset to 0 on every start.

Reset
REQ-024 rst SHALL force state IDLE, count 0, decision EQ, and busy=done=lesser=greater=equal=0 on the next edge.
REQ-025 rst SHALL take priority over start and bit_valid.
REQ-026 rst mid-COMPARE SHALL abort the operation with no done pulse; further bit_valid SHALL be ignored until the next start.

Structure
REQ-027 The shared package SHALL hold the state enum (IDLE/COMPARE/DONE), the decision enum (EQ/LT/GT) and the default WIDTH constant.
REQ-028 The bit counter SHALL be a sub-module named bit_counter, with clear, enable and terminal-count output; the FSM and decision logic SHALL live in serial_comparator.

Verification (WIDTH=8)
REQ-029 Bench SHALL cover: a=0xA5, b=0xA5 sent back-to-back -> done=1 on the cycle after bit 8, with equal=1, lesser=0, greater=0.
REQ-030 Bench SHALL cover: a=0x80, b=0x7F -> greater=1 (decided on the MSB, held through bit 8), done pulse exactly one cycle.
REQ-031 Bench SHALL cover: a=0x12, b=0x13 -> lesser=1 (decided on the LSB only).
REQ-032 Bench SHALL cover: a=0x80, b=0x7F with bit_valid low for 3 cycles between bits 2 and 3 -> same result as REQ-030; done asserted one cycle after the 8th valid bit; busy=1 throughout the gaps.
REQ-033 Bench SHALL cover: rst after 4 accepted bits -> all outputs 0 on the next edge, no done pulse; 4 further bit_valid cycles leave the outputs at 0.
REQ-034 Bench SHALL cover: start asserted in the middle of COMPARE -> ignored, and the original result is produced; start and bit_valid together in IDLE -> that bit is not counted, so 8 more bits are needed.
